// File: rtl/connect4_board_ctrl_if.sv
// Signal bundle between the Connect Four board controller and its environment
// (debounced buttons, mode switch, minimax engine, display).
interface connect4_board_ctrl_if;
    logic        new_game;
    logic        sw;
    logic        btn_drop;
    logic [2:0]  col_sel;
    logic        ai_move;
    logic [6:0]  ai_opt;
    logic [83:0] grid;
    logic [20:0] column_counts;
    logic        player;
    logic        busy;
    logic [1:0]  winner;
    logic        game_over;
    logic        illegal;
    logic [2:0]  last_col;

    modport master (
        output new_game, sw, btn_drop, col_sel, ai_move, ai_opt,
        input  grid, column_counts, player, busy, winner, game_over, illegal, last_col
    );

    modport slave (
        input  new_game, sw, btn_drop, col_sel, ai_move, ai_opt,
        output grid, column_counts, player, busy, winner, game_over, illegal, last_col
    );
endinterface

// File: rtl/connect4_board_ctrl.sv
// Connect Four board owner: accepts human drops and minimax moves, applies them,
// then scans the 24 neighbours of the placed piece for a win or a draw.
module connect4_board_ctrl #(
    parameter int CHECK_STEPS = 24
) (
    input logic                  clk,
    input logic                  rst,
    connect4_board_ctrl_if.slave bus
);

    typedef enum logic [1:0] {TURN, APPLY, CHECK, DONE} state_t;

    state_t      state, state_next;
    logic [83:0] grid;
    logic [20:0] counts;
    logic        player;
    logic [1:0]  winner;
    logic        game_over;
    logic        illegal;
    logic [2:0]  last_col;
    logic [5:0]  move_cnt;
    logic [2:0]  cur_col;
    logic [2:0]  cur_row;
    logic [4:0]  step;
    logic [2:0]  run;
    logic        ext;
    logic        win;

    logic        clear;
    logic [1:0]  mover;
    logic        human_ok, ai_en, ai_legal, accept;
    logic [2:0]  ai_col, fb_col, pick_col;
    logic        match, dir_win, win_now, last_step;
    logic [2:0]  run_new;
    int          wr_idx;

    // Column 7 does not exist; reporting it as full keeps it from ever being chosen.
    function automatic logic [2:0] height(input logic [20:0] cc, input logic [2:0] c);
        if (c > 3'd6) return 3'd6;
        return cc[3*int'(c) + 2 -: 3];
    endfunction

    assign clear    = rst | bus.new_game;
    assign mover    = player ? 2'b10 : 2'b01;
    assign ai_en    = bus.ai_move & player & bus.sw;
    assign human_ok = bus.btn_drop && (!player || !bus.sw) && (height(counts, bus.col_sel) < 3'd6);
    assign accept   = (state == TURN) && (ai_en || human_ok);
    assign wr_idx   = 13 - 2*int'(cur_col) + 14*int'(cur_row);

    always_comb begin
        int opt, r, c;
        opt      = int'(bus.ai_opt);
        r        = opt / 14;
        c        = (13 - opt % 14) / 2;
        ai_col   = 3'(c);
        ai_legal = bus.ai_opt[0] && (opt < 84) && (r == int'(height(counts, ai_col)));
        fb_col   = 3'd0;
        for (int k = 6; k >= 0; k--)
            if (height(counts, 3'(k)) < 3'd6) fb_col = 3'(k);
        pick_col = ai_en ? (ai_legal ? ai_col : fb_col) : bus.col_sel;
    end

    // One neighbour per step: step/6 picks the direction, the first three offsets
    // walk the positive sense and the last three the negative sense.
    always_comb begin
        int   dir, sub, sgn, off, dc, dr, nc, nr, idx;
        logic onboard, ext_eff;
        dir = int'(step) / 6;
        sub = int'(step) % 6;
        sgn = (sub < 3) ? 1 : -1;
        off = sub % 3 + 1;
        case (dir)
            0:       begin dc = 1;  dr = 0; end
            1:       begin dc = 0;  dr = 1; end
            2:       begin dc = 1;  dr = 1; end
            default: begin dc = -1; dr = 1; end
        endcase
        nc      = int'(cur_col) + sgn * off * dc;
        nr      = int'(cur_row) + sgn * off * dr;
        onboard = (nc >= 0) && (nc <= 6) && (nr >= 0) && (nr <= 5);
        idx     = onboard ? (13 - 2*nc + 14*nr) : 1;
        ext_eff = (sub == 0 || sub == 3) ? 1'b1 : ext;
        match   = ext_eff && onboard && (grid[idx -: 2] == mover);
        run_new = ((sub == 0) ? 3'd0 : run) + {2'b00, match};
        dir_win = (sub == 5) && (run_new >= 3'd3);
    end

    assign last_step = (step == 5'(CHECK_STEPS - 1));
    assign win_now   = win | dir_win;

    always_ff @(posedge clk) begin
        if (clear) state <= TURN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TURN:    if (accept) state_next = APPLY;
            APPLY:   state_next = CHECK;
            CHECK:   if (last_step) state_next = (win_now || move_cnt == 6'd42) ? DONE : TURN;
            default: state_next = DONE;
        endcase
    end

    always_comb begin
        bus.busy          = (state == APPLY) || (state == CHECK);
        bus.grid          = grid;
        bus.column_counts = counts;
        bus.player        = player;
        bus.winner        = winner;
        bus.game_over     = game_over;
        bus.illegal       = illegal;
        bus.last_col      = last_col;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            grid      <= '0;
            counts    <= '0;
            player    <= 1'b0;
            winner    <= 2'b00;
            game_over <= 1'b0;
            illegal   <= 1'b0;
            last_col  <= 3'd0;
            move_cnt  <= 6'd0;
            cur_col   <= 3'd0;
            cur_row   <= 3'd0;
            step      <= 5'd0;
            run       <= 3'd0;
            ext       <= 1'b0;
            win       <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                TURN: if (accept) begin
                    cur_col <= pick_col;
                    cur_row <= height(counts, pick_col);
                    illegal <= ai_en && !ai_legal;
                end
                APPLY: begin
                    grid[wr_idx -: 2]               <= mover;
                    counts[3*int'(cur_col) + 2 -: 3] <= cur_row + 3'd1;
                    move_cnt <= move_cnt + 6'd1;
                    last_col <= cur_col;
                    step     <= 5'd0;
                    run      <= 3'd0;
                    ext      <= 1'b1;
                    win      <= 1'b0;
                end
                CHECK: begin
                    step <= step + 5'd1;
                    run  <= run_new;
                    ext  <= match;
                    if (dir_win) win <= 1'b1;
                    if (last_step) begin
                        if (win_now) begin
                            winner    <= mover;
                            game_over <= 1'b1;
                        end else if (move_cnt == 6'd42) begin
                            winner    <= 2'b11;
                            game_over <= 1'b1;
                        end else begin
                            player <= ~player;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_connect4_board_ctrl.sv
// Bench for connect4_board_ctrl: directed games plus random play against a
// board-level model of the Connect Four rules.
`timescale 1ns/1ps
module tb_connect4_board_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    connect4_board_ctrl_if bus();
    connect4_board_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    int m_b[7][6];
    int m_cnt[7];
    int m_player, m_winner, m_moves, m_last;
    bit m_over;

    task automatic chk(input string tag, input logic [83:0] got, input logic [83:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void m_reset();
        for (int c = 0; c < 7; c++) begin
            m_cnt[c] = 0;
            for (int r = 0; r < 6; r++) m_b[c][r] = 0;
        end
        m_player = 0; m_winner = 0; m_moves = 0; m_last = 0; m_over = 0;
    endfunction

    function automatic logic [83:0] m_grid();
        logic [83:0] g;
        g = '0;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                g[13 - 2*c + 14*r -: 2] = 2'(m_b[c][r]);
        return g;
    endfunction

    function automatic logic [20:0] m_counts();
        logic [20:0] cc;
        cc = '0;
        for (int c = 0; c < 7; c++) cc[3*c + 2 -: 3] = 3'(m_cnt[c]);
        return cc;
    endfunction

    // Count the mover's line through (c,r) along each of the four directions.
    function automatic bit m_wins(input int c, input int r, input int who);
        int dcs[4] = '{1, 0, 1, -1};
        int drs[4] = '{0, 1, 1, 1};
        for (int d = 0; d < 4; d++) begin
            int n;
            n = 1;
            for (int s = -1; s <= 1; s += 2) begin
                for (int k = 1; k <= 3; k++) begin
                    int x, y;
                    x = c + s*k*dcs[d];
                    y = r + s*k*drs[d];
                    if (x < 0 || x > 6 || y < 0 || y > 5) break;
                    if (m_b[x][y] != who) break;
                    n++;
                end
            end
            if (n >= 4) return 1;
        end
        return 0;
    endfunction

    function automatic void m_apply(input int col);
        int row;
        row = m_cnt[col];
        m_b[col][row] = m_player + 1;
        m_cnt[col]++;
        m_moves++;
        m_last = col;
        if (m_wins(col, row, m_player + 1)) begin
            m_winner = m_player + 1; m_over = 1;
        end else if (m_moves == 42) begin
            m_winner = 3; m_over = 1;
        end else begin
            m_player ^= 1;
        end
    endfunction

    task automatic check_state();
        chk("grid", bus.grid, m_grid());
        chk("column_counts", bus.column_counts, m_counts());
        chk("player", bus.player, m_player);
        chk("busy_idle", bus.busy, 0);
        chk("winner", bus.winner, m_winner);
        chk("game_over", bus.game_over, m_over);
        chk("last_col", bus.last_col, m_last);
    endtask

    task automatic restart(input bit via_rst);
        @(negedge clk);
        if (via_rst) rst = 1'b1; else bus.new_game = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.new_game = 1'b0;
        m_reset();
        check_state();
        chk("illegal_after_reset", bus.illegal, 0);
    endtask

    // Strobe one move, predict acceptance from the rules, follow it to the handover.
    task automatic do_move(input bit use_ai, input int val);
        bit acc, ill;
        int col;
        acc = 0; ill = 0; col = 0;
        if (use_ai && !m_over && m_player == 1 && bus.sw) begin
            int r, c;
            r = val / 14;
            c = (13 - val % 14) / 2;
            acc = 1;
            if (val % 2 == 1 && val < 84 && r == m_cnt[c]) col = c;
            else begin
                ill = 1;
                col = -1;
                for (int k = 0; k < 7; k++) if (col < 0 && m_cnt[k] < 6) col = k;
            end
        end else if (!use_ai && !m_over && (m_player == 0 || !bus.sw) && val <= 6 && m_cnt[val] < 6) begin
            acc = 1;
            col = val;
        end
        @(negedge clk);
        if (use_ai) begin bus.ai_move = 1'b1; bus.ai_opt = val[6:0]; end
        else begin bus.btn_drop = 1'b1; bus.col_sel = val[2:0]; end
        @(negedge clk);
        bus.ai_move = 1'b0; bus.btn_drop = 1'b0;
        chk("illegal", bus.illegal, ill);
        chk("busy_start", bus.busy, acc);
        if (acc) begin
            repeat (24) @(negedge clk);
            chk("busy_last_check", bus.busy, 1);
            @(negedge clk);
            m_apply(col);
        end
        check_state();
    endtask

    task automatic play(input int seq[$]);
        foreach (seq[i]) begin
            if (seq[i] >= 1000) do_move(1, seq[i] - 1000);
            else do_move(0, seq[i]);
        end
    endtask

    initial begin
        int q[$];
        rst = 1'b1;
        bus.new_game = 1'b0; bus.sw = 1'b1; bus.btn_drop = 1'b0; bus.col_sel = 3'd0;
        bus.ai_move = 1'b0; bus.ai_opt = 7'd0;
        m_reset();
        restart(1);

        // First drop in col 0 against the AI
        do_move(0, 0);
        chk("t1_player", bus.player, 1);
        chk("t1_cell", bus.grid[13:12], 2'b01);

        // Vertical human win in col 3 while the AI stacks col 0; later AI strobe ignored
        restart(0);
        bus.sw = 1'b1;
        q = '{3, 1013, 3, 1027, 3, 1041, 3};
        play(q);
        chk("t2_winner", bus.winner, 2'b01);
        do_move(1, 55);

        // Horizontal AI win along row 0
        restart(1);
        q = '{6, 1011, 6, 1009, 6, 1007, 0, 1005};
        play(q);
        chk("t3_winner", bus.winner, 2'b10);

        // Diagonal up-right completed at its lower end, two humans
        restart(0);
        bus.sw = 1'b0;
        q = '{1, 2, 1, 2, 2, 3, 3, 3, 3, 6, 0};
        play(q);
        chk("t3_diag_winner", bus.winner, 2'b01);

        // Full column and bad column ignored, then an illegal AI opt falls back to col 0
        restart(1);
        bus.sw = 1'b0;
        q = '{2, 2, 2, 2, 2, 2, 2, 7, 6, 6, 5};
        play(q);
        bus.sw = 1'b1;
        do_move(1, 1);
        chk("t4_last_col", bus.last_col, 0);

        // 42-move draw: rows filled in column order 0,2,1,3,4,6,5
        restart(0);
        bus.sw = 1'b0;
        q.delete();
        for (int r = 0; r < 6; r++) begin
            q.push_back(0); q.push_back(2); q.push_back(1); q.push_back(3);
            q.push_back(4); q.push_back(6); q.push_back(5);
        end
        play(q);
        chk("t5_draw", bus.winner, 2'b11);

        // Reset in the middle of a check discards the move
        restart(1);
        bus.sw = 1'b0;
        @(negedge clk); bus.btn_drop = 1'b1; bus.col_sel = 3'd4;
        @(negedge clk); bus.btn_drop = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        check_state();
        do_move(0, 3);

        // Random games
        for (int g = 0; g < 8; g++) begin
            restart(g % 2);
            bus.sw = 1'($urandom_range(0, 1));
            for (int k = 0; k < 80 && !m_over; k++) begin
                int pick;
                pick = $urandom_range(0, 9);
                if (m_player == 1 && bus.sw) begin
                    if (pick == 0) do_move(0, $urandom_range(0, 6));
                    else if (pick < 4) do_move(1, $urandom_range(0, 127));
                    else begin
                        int open[$];
                        int c;
                        for (int j = 0; j < 7; j++) if (m_cnt[j] < 6) open.push_back(j);
                        c = open[$urandom_range(0, open.size() - 1)];
                        do_move(1, 13 - 2*c + 14*m_cnt[c]);
                    end
                end else begin
                    if (pick == 0) do_move(1, $urandom_range(0, 127));
                    else do_move(0, $urandom_range(0, 7));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/connect4_board_ctrl.md
Name: connect4_board_ctrl

Overview:
Owns the authoritative Connect Four board and sits on the other end of the minimax interface. It drives grid/column_counts/player into the AI and consumes its opt/move result. It also accepts human drops from debounced buttons, applies moves, runs a sequential win/draw check and hands the turn over. Top level wires its grid output to the display and minimax.

Parameters:
CHECK_STEPS, 24, fixed win-scan length (4 directions x 2 senses x 3 offsets); not intended to be overridden.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
new_game  in  1  1-cycle pulse; same effect as rst on all state
sw  in  1  1 = AI plays player 1; 0 = two-human mode
btn_drop  in  1  1-cycle debounced drop request
col_sel  in  3  column for btn_drop (0..6)
ai_move  in  1  1-cycle strobe from minimax
ai_opt  in  7  minimax cell index (MSB bit of 2-bit cell)
grid  out  84  board; cell (col c, row r) = bits [13-2c+14r -: 2]; 00 empty, 01 player 0, 10 player 1
column_counts  out  21  fill height of col c = bits [3c+2 -: 3], 0..6
player  out  1  side to move: 0 human, 1 AI/second human
busy  out  1  high while a move is applied or checked
winner  out  2  00 none, 01 player 0, 10 player 1, 11 draw
game_over  out  1  high once winner != 00
illegal  out  1  1-cycle pulse when ai_opt is rejected and the fallback is used
last_col  out  3  column of the most recent placed piece

Behaviour:
- Reset/new_game: grid=0, column_counts=0, player=0, busy=0, winner=00, game_over=0, illegal=0, last_col=0, move counter=0, state=TURN. Either one wins over any same-cycle event. Mid-CHECK it aborts the check with no partial update.
- States: TURN, APPLY, CHECK, DONE.
- TURN accepts a human drop (btn_drop) when player=0, or when player=1 and sw=0:
  - col_sel<=6 and count<6 -> latch column, go to APPLY.
  - Otherwise the drop is ignored silently and no state changes.
- TURN accepts ai_move when player=1 and sw=1. btn_drop is ignored in that case. ai_move is ignored in every other state or condition.
- AI decode:
  - r = ai_opt/14, c = (13 - ai_opt%14)/2.
  - Legal iff ai_opt odd, ai_opt<84, and r == column_counts[c].
  - If illegal: pulse illegal and use the lowest-numbered non-full column instead.
- APPLY (1 cycle):
  - Write the cell at the current height: 01 for player 0, 10 for player 1.
  - Increment that column count, increment the move counter, set last_col, busy=1.
  - Updated grid is visible the cycle after APPLY.
- CHECK (exactly 24 cycles, one neighbour cell per cycle):
  - Directions in order: horizontal, vertical, diagonal up-right, diagonal up-left.
  - Per direction: positive offsets 1..3, then negative offsets 1..3.
  - A run stops extending at the first mismatch or off-board cell. Off-board means col outside 0..6 or row outside 0..5; never index outside 0..83.
  - Win if pos_run+neg_run+1 >= 4 in any direction.
- After the 24th check cycle (next cycle):
  - Win: winner = mover's code, game_over=1, state DONE.
  - Otherwise, move counter == 42: winner=11, game_over=1, state DONE.
  - Otherwise: player toggles, busy=0, state TURN.
- player stays unchanged through APPLY/CHECK. After an AI move player stays 1 until the toggle, so minimax does not re-strobe.
- DONE: all move inputs are ignored, busy=0, outputs hold until rst/new_game.
- Human-to-turn-handover latency: 1 (APPLY) + 24 (CHECK) + 1 = 26 cycles from the accepted strobe to the new player value.

Test Plan:
- Empty board, sw=1, btn_drop col_sel=0 -> grid[13:12]=01, column_counts[2:0]=1, last_col=0; busy high 25 cycles; player=1 at cycle 26.
- Human drops col 3 four times, interleaved with AI opt 13,27,41 (col 0 rows 0..2) -> after the 4th drop winner=01, game_over=1, and the later ai_move is ignored.
- Horizontal AI win on row 0 (cols 1..4 as 10, with human stacking col 6) -> winner=10 on the AI's 4th piece; diagonal up-right win detected when the last piece is at the lower end.
- Fill col 2 (six drops, alternating sw=0), then btn_drop col 2 and col_sel=7 -> both ignored: no busy, grid unchanged. AI turn ai_opt=1 with col 6 count=2 -> illegal pulse, piece lands in col 0.
- 42-move no-win script (sw=0) -> winner=11, game_over=1. rst asserted 10 cycles into a CHECK -> all outputs zero next cycle, state TURN.
